// File: rtl/riscv_defs_pkg.sv
// Shared definitions for the multi-cycle RISC-V control sequencer.
//   - state codes broadcast on the 3-bit estado bus
//   - opcode constants and the instruction class enum used by the decoder
//   - control bundle produced by the decoder for the latched instruction
package riscv_defs_pkg;

  localparam int NUM_INSTR_DEF   = 32;
  localparam int MEM_TIMEOUT_DEF = 15;

  // State codes are fixed by the datapath that listens on estado.
  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_FETCH  = 3'b001;
  localparam logic [2:0] ST_EXEC   = 3'b010;
  localparam logic [2:0] ST_DECODE = 3'b011;
  localparam logic [2:0] ST_MEM    = 3'b100;
  localparam logic [2:0] ST_HALT   = 3'b101;
  localparam logic [2:0] ST_ERROR  = 3'b111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

  typedef enum logic [2:0] {
    CL_R, CL_IALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_ECALL, CL_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic alusrc;
    logic memtoreg;
    logic memread;
    logic memwrite;
    logic wr_rd;     // instruction class writes rd (x0 filtered later)
    logic branch;
  } ctrl_t;

  // States that count as "working" for busy and the cycle counter.
  function automatic logic is_busy(input logic [2:0] st);
    return st inside {ST_FETCH, ST_DECODE, ST_MEM, ST_EXEC};
  endfunction

endpackage

// File: rtl/decodificador_ctrl.sv
// Combinational instruction decoder.
//   ir     : latched instruction word
//   iclass : instruction class (R, I-ALU, load, store, branch, ecall, illegal)
//   ctrl   : control bits for that class
//   imm_b  : sign-extended B-type branch offset
module decodificador_ctrl
  import riscv_defs_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_t     iclass,
  output ctrl_t       ctrl,
  output logic [31:0] imm_b
);

  always_comb begin
    iclass = CL_ILLEGAL;
    ctrl   = '0;
    // ecall is an exact-word match; other SYSTEM encodings are illegal here
    if (ir == INSTR_ECALL) begin
      iclass = CL_ECALL;
    end else begin
      case (ir[6:0])
        OP_R: begin
          iclass     = CL_R;
          ctrl.wr_rd = 1'b1;
        end
        OP_IALU: begin
          iclass      = CL_IALU;
          ctrl.alusrc = 1'b1;
          ctrl.wr_rd  = 1'b1;
        end
        OP_LOAD: begin
          iclass        = CL_LOAD;
          ctrl.alusrc   = 1'b1;
          ctrl.memtoreg = 1'b1;
          ctrl.memread  = 1'b1;
          ctrl.wr_rd    = 1'b1;
        end
        OP_STORE: begin
          iclass        = CL_STORE;
          ctrl.alusrc   = 1'b1;
          ctrl.memwrite = 1'b1;
        end
        OP_BRANCH: begin
          iclass      = CL_BRANCH;
          ctrl.branch = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

endmodule

// File: rtl/sequenciador_estados.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> [MEM] -> EXEC.
//   clk, rst_n        : clock, async active-low reset
//   start             : begin/restart (sampled in IDLE and HALT)
//   instr/instr_valid : instruction memory handshake (FETCH waits forever)
//   mem_ready         : data memory completion (MEM, with timeout)
//   zero              : ALU zero flag, used for branches in EXEC
//   estado            : current state code
//   pc, rs1, rs2, rd  : program counter and fields of the latched instruction
//   regiwrite, memtoreg, alusrc, memread, memwrite : registered datapath controls
//   busy, done, erro  : status flags
//   instr_count, ciclos : saturating retired-instruction and busy-cycle counters
module sequenciador_estados
  import riscv_defs_pkg::*;
#(
  parameter int NUM_INSTR   = NUM_INSTR_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [2:0]  estado,
  output logic [31:0] pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        regiwrite,
  output logic        memtoreg,
  output logic        alusrc,
  output logic        memread,
  output logic        memwrite,
  output logic        busy,
  output logic        done,
  output logic        erro,
  output logic [15:0] instr_count,
  output logic [15:0] ciclos
);

  localparam logic [31:0] PC_END  = 32'(NUM_INSTR * 4);
  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  logic [31:0] ir;
  logic [15:0] tcnt;
  iclass_t     iclass;
  ctrl_t       ctrl;
  logic [31:0] imm_b;
  logic [31:0] pc_exec;
  logic [2:0]  estado_nx;
  logic        ctl_live;
  logic        restart;

  decodificador_ctrl u_dec (
    .ir     (ir),
    .iclass (iclass),
    .ctrl   (ctrl),
    .imm_b  (imm_b)
  );

  assign pc_exec = (ctrl.branch && zero) ? pc + imm_b : pc + 32'd4;
  assign restart = (estado == ST_HALT) && start;

  always_comb begin
    estado_nx = estado;
    case (estado)
      ST_IDLE:   if (start) estado_nx = ST_FETCH;
      ST_FETCH:  if (instr_valid) estado_nx = ST_DECODE;
      ST_DECODE: begin
        case (iclass)
          CL_R, CL_IALU, CL_BRANCH: estado_nx = ST_EXEC;
          CL_LOAD, CL_STORE:        estado_nx = ST_MEM;
          CL_ECALL:                 estado_nx = ST_HALT;
          default:                  estado_nx = ST_ERROR;
        endcase
      end
      // ready on the last allowed cycle still completes the access
      ST_MEM: begin
        if (mem_ready)            estado_nx = ST_EXEC;
        else if (tcnt == TO_LAST) estado_nx = ST_ERROR;
      end
      ST_EXEC:  estado_nx = (pc_exec >= PC_END) ? ST_HALT : ST_FETCH;
      ST_HALT:  if (start) estado_nx = ST_FETCH;
      ST_ERROR: estado_nx = ST_ERROR;
      default:  estado_nx = ST_ERROR;
    endcase
  end

  // Controls are registered from the state being entered, so they are valid
  // for exactly the MEM/EXEC cycles and fall to zero everywhere else.
  assign ctl_live = (estado_nx == ST_MEM) || (estado_nx == ST_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= ST_IDLE;
      ir          <= '0;
      tcnt        <= '0;
      pc          <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      regiwrite   <= 1'b0;
      memtoreg    <= 1'b0;
      alusrc      <= 1'b0;
      memread     <= 1'b0;
      memwrite    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      erro        <= 1'b0;
      instr_count <= '0;
      ciclos      <= '0;
    end else begin
      estado <= estado_nx;
      busy   <= is_busy(estado_nx);
      done   <= (estado_nx == ST_HALT);
      erro   <= (estado_nx == ST_ERROR);

      if (estado == ST_FETCH && instr_valid) ir <= instr;

      if (estado == ST_DECODE) begin
        rs1 <= ir[19:15];
        rs2 <= ir[24:20];
        rd  <= ir[11:7];
      end

      regiwrite <= (estado_nx == ST_EXEC) && ctrl.wr_rd && (ir[11:7] != 5'd0);
      memread   <= (estado_nx == ST_MEM) && ctrl.memread;
      memwrite  <= (estado_nx == ST_MEM) && ctrl.memwrite;
      alusrc    <= ctl_live && ctrl.alusrc;
      memtoreg  <= ctl_live && ctrl.memtoreg;

      tcnt <= (estado == ST_MEM && estado_nx == ST_MEM) ? tcnt + 16'd1 : '0;

      if (estado == ST_EXEC)  pc <= pc_exec;
      else if (restart)       pc <= '0;

      if (restart)
        instr_count <= '0;
      else if (estado == ST_EXEC && instr_count != 16'hFFFF)
        instr_count <= instr_count + 16'd1;

      if (restart)
        ciclos <= '0;
      else if (is_busy(estado) && ciclos != 16'hFFFF)
        ciclos <= ciclos + 16'd1;
    end
  end

endmodule

// File: tb/tb_sequenciador_estados.sv
module tb_sequenciador_estados;

  localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_EXEC = 3'b010,
                         S_DEC  = 3'b011, S_MEM   = 3'b100, S_HALT = 3'b101,
                         S_ERR  = 3'b111;
  localparam logic [31:0] LIMIT = 32'd128;  // 32 words

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        instr_valid = 1'b0, mem_ready = 1'b0, zero = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  estado;
  logic [31:0] pc;
  logic [4:0]  rs1, rs2, rd;
  logic        regiwrite, memtoreg, alusrc, memread, memwrite, busy, done, erro;
  logic [15:0] instr_count, ciclos;

  always #5 clk = ~clk;

  sequenciador_estados dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .instr_valid(instr_valid), .mem_ready(mem_ready), .zero(zero),
    .estado(estado), .pc(pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .regiwrite(regiwrite), .memtoreg(memtoreg), .alusrc(alusrc),
    .memread(memread), .memwrite(memwrite), .busy(busy), .done(done),
    .erro(erro), .instr_count(instr_count), .ciclos(ciclos)
  );

  // One entry per clock cycle: inputs to apply plus outputs expected.
  typedef struct packed {
    logic        i_start, i_iv, i_mr, i_z;
    logic [31:0] i_instr;
    logic [2:0]  st;
    logic [31:0] pc;
    logic        rw, mtr, src, mrd, mwr, bsy, dn, er;
    logic [15:0] cnt, cyc;
    logic        chk_rd;
    logic [4:0]  rd;
  } ent_t;

  ent_t        q[$];
  ent_t        w;
  int          total = 0, bad = 0;
  logic [31:0] mpc = '0;
  logic [15:0] mcnt = '0, mcyc = '0;
  logic [2:0]  nx;

  function automatic void blank(input logic [2:0] s);
    w     = '0;
    w.st  = s;
    w.pc  = mpc;
    w.cnt = mcnt;
    w.cyc = mcyc;
    w.bsy = (s == S_FETCH) || (s == S_DEC) || (s == S_MEM) || (s == S_EXEC);
    w.dn  = (s == S_HALT);
    w.er  = (s == S_ERR);
  endfunction

  function automatic void push();
    q.push_back(w);
    if (w.bsy && mcyc != 16'hFFFF) mcyc = mcyc + 16'd1;
  endfunction

  // n cycles parked in IDLE/HALT/ERROR; start raised on the last one
  function automatic void quiet(input logic [2:0] s, input int n, input logic st_last);
    for (int i = 0; i < n; i++) begin
      blank(s);
      if (i == n - 1) w.i_start = st_last;
      push();
    end
    if (s == S_HALT && st_last) begin
      mpc = '0; mcnt = '0; mcyc = '0;
    end
  endfunction

  // Whole-instruction trace from the architectural rules.
  // fw: FETCH stall cycles, mw: MEM cycle carrying mem_ready (0 = never).
  function automatic logic [2:0] instr_tr(input logic [31:0] ir, input int fw,
                                           input int mw, input logic z);
    logic r, ia, ld, sv, br, ok;
    int   off;
    r  = ir[6:0] == 7'h33;
    ia = ir[6:0] == 7'h13;
    ld = ir[6:0] == 7'h03;
    sv = ir[6:0] == 7'h23;
    br = ir[6:0] == 7'h63;
    for (int i = 0; i < fw; i++) begin
      blank(S_FETCH); w.i_instr = 32'hFFFF_FFFF; push();
    end
    blank(S_FETCH); w.i_iv = 1'b1; w.i_instr = ir; push();
    blank(S_DEC); push();
    if (ir == 32'h73) return S_HALT;
    if (!(r || ia || ld || sv || br)) return S_ERR;
    if (ld || sv) begin
      ok = 1'b0;
      for (int k = 1; k <= 15 && !ok; k++) begin
        blank(S_MEM);
        w.src = 1'b1; w.mtr = ld; w.mrd = ld; w.mwr = sv;
        w.chk_rd = 1'b1; w.rd = ir[11:7];
        if (k == mw) begin w.i_mr = 1'b1; ok = 1'b1; end
        push();
      end
      if (!ok) return S_ERR;
    end
    blank(S_EXEC);
    w.src = ia || ld || sv;
    w.mtr = ld;
    w.rw  = (r || ia || ld) && (ir[11:7] != 5'd0);
    w.chk_rd = 1'b1; w.rd = ir[11:7];
    w.i_z = z;
    push();
    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    off = (ir[31] ? -4096 : 0) + 2048 * int'(ir[7]) + 32 * int'(ir[30:25]) + 2 * int'(ir[11:8]);
    mpc = (br && z) ? mpc + 32'(off) : mpc + 32'd4;
    return (mpc >= LIMIT) ? S_HALT : S_FETCH;
  endfunction

  task automatic run_q();
    ent_t e;
    logic [74:0] got, exp;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      got = {estado, pc, regiwrite, memtoreg, alusrc, memread, memwrite, busy, done, erro,
             instr_count, ciclos};
      exp = {e.st, e.pc, e.rw, e.mtr, e.src, e.mrd, e.mwr, e.bsy, e.dn, e.er, e.cnt, e.cyc};
      total++;
      if (got !== exp || (e.chk_rd && rd !== e.rd)) begin
        bad++;
        $display("FAIL cycle@%0t got=%h rd=%0d exp=%h rd=%0d", $time, got, rd, exp, e.rd);
      end
      start = e.i_start; instr_valid = e.i_iv; instr = e.i_instr;
      mem_ready = e.i_mr; zero = e.i_z;
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; zero = 1'b0; instr = '0;
    #1;
    lit("rst estado", 32'(estado), 32'(S_IDLE));
    lit("rst pc", pc, 32'd0);
    lit("rst counters", {instr_count, ciclos}, 32'd0);
    lit("rst flags", 32'({regiwrite, memtoreg, alusrc, memread, memwrite, busy, done, erro}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mpc = '0; mcnt = '0; mcyc = '0;
  endtask

  initial begin
    do_reset();

    // add x3,x1,x2 with one FETCH stall
    quiet(S_IDLE, 2, 1'b1);
    nx = instr_tr(32'h002081B3, 1, 0, 1'b0);
    lit("add next", 32'(nx), 32'(S_FETCH));
    run_q(); settle();
    lit("add pc", pc, 32'd4);
    lit("add count", 32'(instr_count), 32'd1);
    lit("add rd", 32'(rd), 32'd3);

    // beq +8 taken at pc=4, then not taken at pc=12
    nx = instr_tr(32'h00000463, 0, 0, 1'b1);
    run_q(); settle();
    lit("beq taken pc", pc, 32'd12);
    nx = instr_tr(32'h00000463, 0, 0, 1'b0);
    run_q(); settle();
    lit("beq not taken pc", pc, 32'd16);

    // addi x0,x0,1: retires with no write
    nx = instr_tr(32'h00100013, 0, 0, 1'b0);
    run_q(); settle();
    lit("addi x0 count", 32'(instr_count), 32'd4);

    // ecall halts; restart clears pc and counters
    nx = instr_tr(32'h00000073, 0, 0, 1'b0);
    lit("ecall next", 32'(nx), 32'(S_HALT));
    quiet(S_HALT, 3, 1'b1);
    run_q(); settle();
    lit("restart state", 32'(estado), 32'(S_FETCH));
    lit("restart pc+cnt", pc | 32'(instr_count) | 32'(ciclos), 32'd0);

    // lw x5,0(x0), ready on 3rd MEM cycle
    nx = instr_tr(32'h00002283, 0, 3, 1'b0);
    run_q(); settle();
    lit("lw ciclos", 32'(ciclos), 32'd6);
    lit("lw rd", 32'(rd), 32'd5);

    // backward branch -4, forward +124, then addi reaching the end of program
    nx = instr_tr(32'hFE000EE3, 0, 0, 1'b1);
    run_q(); settle();
    lit("beq -4 pc", pc, 32'd0);
    nx = instr_tr(32'h06000E63, 0, 0, 1'b1);
    run_q(); settle();
    lit("beq +124 pc", pc, 32'd124);
    nx = instr_tr(32'h00100093, 0, 0, 1'b0);
    lit("end next", 32'(nx), 32'(S_HALT));
    quiet(S_HALT, 2, 1'b0);
    run_q(); settle();
    lit("end pc", pc, 32'd128);
    lit("end done", 32'(done), 32'd1);
    quiet(S_HALT, 1, 1'b1);

    // sw with no mem_ready: timeout into sticky ERROR, start ignored
    nx = instr_tr(32'h00502023, 0, 0, 1'b0);
    lit("sw next", 32'(nx), 32'(S_ERR));
    quiet(S_ERR, 4, 1'b1);
    quiet(S_ERR, 2, 1'b0);
    run_q(); settle();
    lit("sw estado", 32'(estado), 32'(S_ERR));
    lit("sw memwrite", 32'(memwrite), 32'd0);
    lit("sw pc", pc, 32'd0);

    // illegal opcode traps right after DECODE
    do_reset();
    quiet(S_IDLE, 1, 1'b1);
    nx = instr_tr(32'hFFFFFFFF, 0, 0, 1'b0);
    lit("illegal next", 32'(nx), 32'(S_ERR));
    quiet(S_ERR, 2, 1'b0);
    run_q(); settle();
    lit("illegal erro", 32'(erro), 32'd1);
    lit("illegal count", 32'(instr_count), 32'd0);

    // asynchronous reset in the middle of a load
    do_reset();
    quiet(S_IDLE, 1, 1'b1);
    nx = instr_tr(32'h00002283, 0, 0, 1'b0);
    while (q.size() > 5) void'(q.pop_back());
    run_q();
    lit("mid-mem memread", 32'(memread), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    lit("async memread", 32'(memread), 32'd0);
    lit("async estado", 32'(estado), 32'(S_IDLE));
    lit("async ctl", 32'({alusrc, memtoreg, busy, ciclos}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequenciador_estados.md
Name: sequenciador_estados

Overview:
- Multi-cycle control sequencer for the RISC-V datapath.
- Drives the shared 3-bit `estado` bus, the PC, and the register-bank controls (`regiwrite`, `memtoreg`, rs1/rs2/rd).
- Sequences each instruction FETCH -> DECODE -> [MEM] -> EXEC, so the register bank reads and commits only in EXEC (3'b010).
- Handles instruction/data-memory handshakes, halting, error trapping and performance counters.

Parameters:
- NUM_INSTR, 32: program size in words; PC reaching NUM_INSTR*4 halts the core.
- MEM_TIMEOUT, 15: maximum cycles waiting for mem_ready in MEM before trapping to ERROR.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin or restart execution (level, sampled in IDLE/HALT)
- instr  in  32  instruction word from instruction memory
- instr_valid  in  1  instr valid this cycle
- mem_ready  in  1  data memory completed the access
- zero  in  1  ALU zero flag, valid in EXEC
- estado  out  3  state code broadcast to datapath
- pc  out  32  program counter
- rs1, rs2, rd  out  5 each  register fields of latched instruction
- regiwrite  out  1  register-bank write enable
- memtoreg  out  1  select load data for write-back
- alusrc  out  1  ALU operand B = immediate
- memread, memwrite  out  1 each  data memory strobes
- busy  out  1  high in FETCH/DECODE/MEM/EXEC
- done  out  1  high in HALT
- erro  out  1  high in ERROR
- instr_count  out  16  retired instructions
- ciclos  out  16  cycles spent out of IDLE/HALT/ERROR

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0, including pc, the internal IR, both counters and the timeout counter.
  - Reset mid-instruction aborts the instruction immediately; no write strobe survives.
- State encodings: IDLE 000, FETCH 001, EXEC 010, DECODE 011, MEM 100, HALT 101, ERROR 111.
  - estado = current state register, which is a direct register output.
- IDLE: start=1 -> FETCH next cycle.
- FETCH: waits on instr_valid.
  - On instr_valid=1, latch instr into IR, then go to DECODE.
  - No timeout in FETCH.
- DECODE: classify IR[6:0] and register rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7]. Per class:
  - R (0110011): alusrc=0, next EXEC.
  - I-ALU (0010011): alusrc=1, next EXEC.
  - Load (0000011): alusrc=1, memtoreg=1, next MEM.
  - Store (0100011): alusrc=1, next MEM.
  - Branch (1100011): alusrc=0, next EXEC.
  - IR==32'h00000073 (ecall): next HALT, instr_count unchanged.
  - Any other opcode: next ERROR.
- MEM: memread (load) or memwrite (store) held high while in MEM.
  - mem_ready=1 -> drop strobe, go to EXEC.
  - Timeout counter increments each MEM cycle without mem_ready; reaching MEM_TIMEOUT -> ERROR.
  - mem_ready=1 on the same cycle the counter reaches the limit: success wins.
- EXEC: exactly one cycle.
  - regiwrite=1 for R/I-ALU/load only if rd!=0; x0 writes suppressed.
  - memtoreg stays 1 for load.
  - On exit: instr_count+1 (saturates at 16'hFFFF); controls cleared.
  - PC update: branch with zero=1 -> pc + sign-extended B-immediate {IR[31],IR[7],IR[30:25],IR[11:8],0}; otherwise pc+4, 32-bit wrap.
  - Next state: if updated pc >= NUM_INSTR*4 then HALT, else FETCH.
- HALT: done=1. start=1 -> clear pc and both counters, go to FETCH.
- ERROR: erro=1; sticky until rst_n. pc frozen at the offending instruction.
- ciclos increments every cycle in FETCH/DECODE/MEM/EXEC, saturating.
- Control outputs are registered and glitch-free. Only one of memread/memwrite/regiwrite is ever high in a cycle.

Decomposition:
- Shared package `riscv_defs_pkg`: state encodings, opcode constants, NUM_INSTR default.
- One sub-module `decodificador_ctrl`: combinational opcode -> class/control bits plus immediate extraction. The sequencer instantiates it once on the IR.

Test Plan:
- Reset then start=1, instr_valid=1 with add x3,x1,x2 (0x002081B3): estado 001->011->010->001; regiwrite=1 only in 010; rd=3; pc=4; instr_count=1.
- lw x5,0(x0) (0x00002283) with mem_ready after 3 cycles: memread high 3 cycles in 100, then 010 with regiwrite=1 and memtoreg=1; ciclos=6.
- sw (0x00502023) with mem_ready never asserted: after 15 MEM cycles estado=111, erro=1, memwrite=0; start ignored until rst_n pulse.
- beq offset +8 (0x00000463) with zero=1 at pc=4 -> pc=12; with zero=0 -> pc=8; regiwrite never asserted.
- addi x0,x0,1 (0x00100013): regiwrite stays 0 in EXEC, instr_count increments.
- Illegal opcode 0xFFFFFFFF -> ERROR after DECODE. ecall 0x00000073 -> HALT, done=1. Then start=1 restarts with pc=0 and counters=0. rst_n low mid-MEM clears memread asynchronously.
